// File: rtl/vibrometer_pkg.sv
// Shared definitions for the vibrometer sign-finder datapath.
//   sf_state_e     : controller FSM encoding (also exported on ST_state)
//   LogCountWidth  : width of the hysteresis log count
//   CfgTargetWidth : width of the half-period target limits
//   rec_sign_pos() : bit position of the sign field inside an output record
//   RecDurLsb      : least significant bit of the duration field
package vibrometer_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StMeasure = 2'd2
  } sf_state_e;

  localparam int unsigned LogCountWidth  = 5;
  localparam int unsigned CfgTargetWidth = 32;

  // Record layout: sign in the MSB, duration filling every bit below it.
  localparam int unsigned RecDurLsb = 0;

  function automatic int unsigned rec_sign_pos(input int unsigned tdata_width);
    return tdata_width - 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream output register with drop indication.
//   SYS_aclk, SYS_reset : clock, synchronous active-high reset
//   push_i, data_i      : offer a new record this cycle
//   ready_i             : downstream tready
//   valid_o, data_o     : registered tvalid / tdata, stable until handshake
//   drop_o              : pushed record could not be stored (slot busy, no handshake)
module axis_reg_slice #(
  parameter int unsigned Width = 32
) (
  input  logic             SYS_aclk,
  input  logic             SYS_reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             drop_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;
  logic             accept;

  // The slot frees up in the same cycle it is handshaken, so a push can land then.
  always_comb begin
    accept = push_i && (!valid_q || ready_i);
    drop_o = push_i && !accept;
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sign_finder_ctrl.sv
// Sign-finder controller: measures half-period lengths between sign edges,
// emits {sign, duration} records on AXI-Stream and optionally auto-ranges the
// sign finder's hysteresis log count toward a target half-period window.
//   SYS_aclk, SYS_reset          : clock, synchronous active-high reset
//   CFG_enable, CFG_auto         : run enable, auto-ranging enable
//   CFG_log_count                : manual log count / auto start value
//   CFG_target_min/max           : acceptable half-period window in cycles
//   SF_sign, SF_log_count        : sign finder direction in, log count out
//   M_AXIS_tvalid/tdata/tready   : record output stream
//   ST_overflow, ST_state        : sticky drop flag, FSM state
module sign_finder_ctrl
  import vibrometer_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned LOG_COUNT_MAX    = 20
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_reset,
  input  logic                        CFG_enable,
  input  logic                        CFG_auto,
  input  logic [LogCountWidth-1:0]    CFG_log_count,
  input  logic [CfgTargetWidth-1:0]   CFG_target_min,
  input  logic [CfgTargetWidth-1:0]   CFG_target_max,
  input  logic                        SF_sign,
  output logic [LogCountWidth-1:0]    SF_log_count,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  input  logic                        M_AXIS_tready,
  output logic                        ST_overflow,
  output logic [1:0]                  ST_state
);

  localparam int unsigned SignPos  = rec_sign_pos(AXIS_TDATA_WIDTH);
  localparam int unsigned DurWidth = SignPos - RecDurLsb;
  localparam int unsigned CmpWidth = (DurWidth > CfgTargetWidth) ? DurWidth : CfgTargetWidth;

  localparam logic [DurWidth-1:0]      DurOne = DurWidth'(1);
  localparam logic [LogCountWidth-1:0] LogOne = LogCountWidth'(1);
  localparam logic [LogCountWidth-1:0] LogMax = LogCountWidth'(LOG_COUNT_MAX);

  sf_state_e                  state_q;
  logic [DurWidth-1:0]        dur_q;
  logic                       sign_q;      // SF_sign delayed by one cycle
  logic                       enable_q;    // for rising-edge detect of CFG_enable
  logic                       overflow_q;
  logic [LogCountWidth-1:0]   log_count_q;

  logic                        edge_det;
  logic                        dur_sat;
  logic                        can_inc;
  logic                        can_dec;
  logic [CmpWidth-1:0]         dur_ext;
  logic [CmpWidth-1:0]         min_ext;
  logic [CmpWidth-1:0]         max_ext;
  logic                        rec_push;
  logic [AXIS_TDATA_WIDTH-1:0] rec_data;
  logic                        rec_drop;

  always_comb begin
    edge_det = SF_sign != sign_q;
    dur_sat  = &dur_q;
    dur_ext  = CmpWidth'(dur_q);
    min_ext  = CmpWidth'(CFG_target_min);
    max_ext  = CmpWidth'(CFG_target_max);
    // Bound checks fold REQ'd saturation at 0 / LOG_COUNT_MAX into the decision.
    can_inc  = (dur_ext < min_ext) && (log_count_q < LogMax);
    can_dec  = (dur_ext > max_ext) && (log_count_q != '0);
    // A disable in the same cycle wins over a closing edge.
    rec_push = CFG_enable && (state_q == StMeasure) && edge_det;
    rec_data = '0;
    rec_data[SignPos]                 = sign_q;
    rec_data[SignPos-1:RecDurLsb]     = dur_q;
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      state_q     <= StIdle;
      dur_q       <= '0;
      sign_q      <= 1'b1;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      log_count_q <= '0;
    end else begin
      sign_q   <= SF_sign;
      enable_q <= CFG_enable;

      if (CFG_enable && !enable_q) begin
        overflow_q <= 1'b0;
      end else if (rec_drop) begin
        overflow_q <= 1'b1;
      end

      // Manual mode tracks the config in every state, including idle.
      if (!CFG_auto) begin
        log_count_q <= CFG_log_count;
      end

      if (!CFG_enable) begin
        state_q <= StIdle;
        dur_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q     <= StAcquire;
            log_count_q <= CFG_log_count;
          end
          StAcquire: begin
            if (edge_det) begin
              dur_q   <= DurOne;
              state_q <= StMeasure;
            end
          end
          StMeasure: begin
            if (edge_det) begin
              dur_q <= DurOne;
              // A range change invalidates the running phase; resync on the next edge.
              if (CFG_auto && can_inc) begin
                log_count_q <= log_count_q + LogOne;
                state_q     <= StAcquire;
              end else if (CFG_auto && can_dec) begin
                log_count_q <= log_count_q - LogOne;
                state_q     <= StAcquire;
              end
            end else if (!dur_sat) begin
              dur_q <= dur_q + DurOne;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  axis_reg_slice #(
    .Width(AXIS_TDATA_WIDTH)
  ) u_slice (
    .SYS_aclk (SYS_aclk),
    .SYS_reset(SYS_reset),
    .push_i   (rec_push),
    .data_i   (rec_data),
    .ready_i  (M_AXIS_tready),
    .valid_o  (M_AXIS_tvalid),
    .data_o   (M_AXIS_tdata),
    .drop_o   (rec_drop)
  );

  assign SF_log_count = log_count_q;
  assign ST_overflow  = overflow_q;
  assign ST_state     = state_q;

endmodule

// File: tb/tb_sign_finder_ctrl.sv
// Self-checking bench for sign_finder_ctrl: scoreboard of expected records
// plus directed checks of state, log count and overflow. A second instance
// with an 8-bit record exercises duration saturation in a short run.
module tb_sign_finder_ctrl;

  logic        SYS_aclk;
  logic        SYS_reset;
  logic        CFG_enable;
  logic        CFG_auto;
  logic [4:0]  CFG_log_count;
  logic [31:0] CFG_target_min;
  logic [31:0] CFG_target_max;
  logic        SF_sign;
  logic [4:0]  SF_log_count;
  logic        M_AXIS_tvalid;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tready;
  logic        ST_overflow;
  logic [1:0]  ST_state;

  logic        sm_enable;
  logic        sm_sign;
  logic [4:0]  sm_log_count;
  logic        sm_tvalid;
  logic [7:0]  sm_tdata;
  logic        sm_tready;
  logic        sm_overflow;
  logic [1:0]  sm_state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];

  initial SYS_aclk = 1'b0;
  always #5 SYS_aclk = ~SYS_aclk;

  sign_finder_ctrl #(
    .AXIS_TDATA_WIDTH(32),
    .LOG_COUNT_MAX   (20)
  ) dut (
    .SYS_aclk      (SYS_aclk),
    .SYS_reset     (SYS_reset),
    .CFG_enable    (CFG_enable),
    .CFG_auto      (CFG_auto),
    .CFG_log_count (CFG_log_count),
    .CFG_target_min(CFG_target_min),
    .CFG_target_max(CFG_target_max),
    .SF_sign       (SF_sign),
    .SF_log_count  (SF_log_count),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tready (M_AXIS_tready),
    .ST_overflow   (ST_overflow),
    .ST_state      (ST_state)
  );

  sign_finder_ctrl #(
    .AXIS_TDATA_WIDTH(8),
    .LOG_COUNT_MAX   (20)
  ) dut_small (
    .SYS_aclk      (SYS_aclk),
    .SYS_reset     (SYS_reset),
    .CFG_enable    (sm_enable),
    .CFG_auto      (1'b0),
    .CFG_log_count (5'd1),
    .CFG_target_min(32'd0),
    .CFG_target_max(32'hFFFF_FFFF),
    .SF_sign       (sm_sign),
    .SF_log_count  (sm_log_count),
    .M_AXIS_tvalid (sm_tvalid),
    .M_AXIS_tdata  (sm_tdata),
    .M_AXIS_tready (sm_tready),
    .ST_overflow   (sm_overflow),
    .ST_state      (sm_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_rec(input logic s, input logic [30:0] d);
    return {s, d};
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(posedge SYS_aclk);
    #1;
  endtask

  // Toggle the sign; the DUT sees the edge on the next rising clock.
  task automatic toggle(input bit expect_rec, input int unsigned dur);
    if (expect_rec) exp_q.push_back(mk_rec(SF_sign, 31'(dur)));
    SF_sign = ~SF_sign;
    step(1);
  endtask

  task automatic apply_reset();
    CFG_enable = 1'b0;
    SYS_reset  = 1'b1;
    step(1);
    SYS_reset  = 1'b0;
    exp_q.delete();
  endtask

  // Records are consumed at the handshake edge following this sample point.
  always @(negedge SYS_aclk) begin
    if (!SYS_reset && M_AXIS_tvalid && M_AXIS_tready) begin
      check_eq("rec_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("rec_data", 64'(M_AXIS_tdata), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] first_rec;
    logic        old_sign;

    SYS_reset      = 1'b1;
    CFG_enable     = 1'b0;
    CFG_auto       = 1'b0;
    CFG_log_count  = 5'd0;
    CFG_target_min = 32'd10;
    CFG_target_max = 32'd1000;
    SF_sign        = 1'b1;
    M_AXIS_tready  = 1'b1;
    sm_enable      = 1'b0;
    sm_sign        = 1'b1;
    sm_tready      = 1'b0;
    step(2);
    check_eq("rst_state", 64'(ST_state), 64'd0);
    check_eq("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("rst_tdata", 64'(M_AXIS_tdata), 64'd0);
    check_eq("rst_log", 64'(SF_log_count), 64'd0);
    check_eq("rst_ovf", 64'(ST_overflow), 64'd0);
    SYS_reset = 1'b0;

    // Manual log count follows config even while idle.
    CFG_log_count = 5'd9;
    step(1);
    check_eq("idle_manual_log", 64'(SF_log_count), 64'd9);
    check_eq("idle_state", 64'(ST_state), 64'd0);

    // Manual enable.
    CFG_log_count = 5'd7;
    CFG_enable    = 1'b1;
    step(1);
    check_eq("en_log", 64'(SF_log_count), 64'd7);
    check_eq("en_state", 64'(ST_state), 64'd1);

    // Period 100 inside the window: records flow, log count untouched.
    CFG_auto = 1'b1;
    toggle(0, 0);
    check_eq("acq_to_meas", 64'(ST_state), 64'd2);
    step(99);
    for (int i = 0; i < 4; i++) begin
      toggle(1, 100);
      step(99);
    end
    check_eq("win_log", 64'(SF_log_count), 64'd7);
    check_eq("win_state", 64'(ST_state), 64'd2);
    CFG_target_max = 32'd50;
    toggle(1, 100);
    check_eq("dec_log", 64'(SF_log_count), 64'd6);
    check_eq("dec_state", 64'(ST_state), 64'd1);
    step(5);
    check_eq("drain_a", 64'(exp_q.size()), 64'd0);

    // Auto increment on short half-periods, restart in acquire.
    apply_reset();
    CFG_auto       = 1'b1;
    CFG_log_count  = 5'd3;
    CFG_target_min = 32'd10;
    CFG_target_max = 32'd1000;
    CFG_enable     = 1'b1;
    step(1);
    toggle(0, 0);
    step(4);
    toggle(1, 5);
    check_eq("inc_log", 64'(SF_log_count), 64'd4);
    check_eq("inc_state", 64'(ST_state), 64'd1);
    step(4);
    toggle(0, 0);
    check_eq("reacq_state", 64'(ST_state), 64'd2);
    check_eq("reacq_log", 64'(SF_log_count), 64'd4);
    step(4);
    toggle(1, 5);
    check_eq("inc2_log", 64'(SF_log_count), 64'd5);
    CFG_auto      = 1'b0;
    CFG_log_count = 5'd12;
    step(1);
    check_eq("to_manual_log", 64'(SF_log_count), 64'd12);
    step(3);
    check_eq("drain_b", 64'(exp_q.size()), 64'd0);

    // At the lower bound a long half-period changes nothing.
    apply_reset();
    CFG_auto       = 1'b1;
    CFG_log_count  = 5'd0;
    CFG_target_max = 32'd50;
    CFG_enable     = 1'b1;
    step(1);
    toggle(0, 0);
    step(99);
    toggle(1, 100);
    check_eq("bound_log", 64'(SF_log_count), 64'd0);
    check_eq("bound_state", 64'(ST_state), 64'd2);
    step(3);

    // Backpressure: first record held, second dropped.
    apply_reset();
    CFG_auto       = 1'b0;
    CFG_log_count  = 5'd2;
    CFG_target_max = 32'd1000;
    M_AXIS_tready  = 1'b0;
    CFG_enable     = 1'b1;
    step(1);
    toggle(0, 0);
    step(19);
    first_rec = mk_rec(SF_sign, 31'd20);
    toggle(1, 20);
    check_eq("bp_valid", 64'(M_AXIS_tvalid), 64'd1);
    check_eq("bp_data1", 64'(M_AXIS_tdata), 64'(first_rec));
    check_eq("bp_ovf0", 64'(ST_overflow), 64'd0);
    step(19);
    toggle(0, 0);
    check_eq("bp_data2", 64'(M_AXIS_tdata), 64'(first_rec));
    check_eq("bp_ovf1", 64'(ST_overflow), 64'd1);
    CFG_enable = 1'b0;
    step(1);
    check_eq("dis_state", 64'(ST_state), 64'd0);
    check_eq("dis_valid", 64'(M_AXIS_tvalid), 64'd1);
    check_eq("dis_ovf", 64'(ST_overflow), 64'd1);
    M_AXIS_tready = 1'b1;
    step(1);
    check_eq("dis_drained", 64'(M_AXIS_tvalid), 64'd0);
    CFG_enable = 1'b1;
    step(1);
    check_eq("reen_ovf", 64'(ST_overflow), 64'd0);
    check_eq("reen_state", 64'(ST_state), 64'd1);

    // Reset while a record is pending in MEASURE.
    CFG_auto      = 1'b1;
    M_AXIS_tready = 1'b0;
    toggle(0, 0);
    step(29);
    toggle(1, 30);
    check_eq("pre_rst_valid", 64'(M_AXIS_tvalid), 64'd1);
    check_eq("pre_rst_state", 64'(ST_state), 64'd2);
    check_eq("pre_rst_log", 64'(SF_log_count), 64'd2);
    SYS_reset = 1'b1;
    step(1);
    check_eq("mid_rst_valid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("mid_rst_state", 64'(ST_state), 64'd0);
    check_eq("mid_rst_log", 64'(SF_log_count), 64'd0);
    check_eq("mid_rst_data", 64'(M_AXIS_tdata), 64'd0);
    SYS_reset = 1'b0;
    exp_q.delete();
    CFG_enable    = 1'b0;
    M_AXIS_tready = 1'b1;
    step(1);

    // Duration saturation on the 8-bit instance (7-bit counter).
    sm_enable = 1'b1;
    step(1);
    sm_sign = ~sm_sign;
    step(1);
    step(200);
    old_sign = sm_sign;
    sm_sign  = ~sm_sign;
    step(1);
    check_eq("sat_valid", 64'(sm_tvalid), 64'd1);
    check_eq("sat_data", 64'(sm_tdata), 64'({old_sign, 7'h7F}));
    check_eq("sat_state", 64'(sm_state), 64'd2);

    step(2);
    check_eq("drain_end", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
